inst_mem_loader: RTL and testbench

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_loader.sv | 124 ++++++++++++
 tb/tb_inst_mem_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction RAM loader: packs a byte stream into 32-bit words
// and writes them from address 0 while holding the CPU.
module inst_mem_loader #(
    parameter int DEPTH      = 64,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  num_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        FINISH
    } state_t;

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_t      state;
    state_t      state_nxt;
    logic [6:0]  word_idx;
    logic [6:0]  num_lat;
    logic [1:0]  byte_cnt;
    logic [31:0] word;
    logic        start_ok;
    logic        byte_acc;
    logic        last_word;

    assign start_ok  = start && (num_words != 7'd0)
                     && (32'(num_words) <= DEPTH_U);
    assign byte_acc  = (state == LOAD) && byte_valid;
    assign last_word = (7'(word_idx + 7'd1) == num_lat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = LOAD;
            LOAD:    if (byte_acc && byte_cnt == 2'd3) state_nxt = WRITE;
            WRITE:   state_nxt = last_word ? FINISH : LOAD;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        unique case (state)
            LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_addr  = {23'd0, word_idx, 2'b00};
    assign mem_wdata = word;
    assign cpu_hold  = ~done;

    // Shifting places the first byte of a word in its final lane after four bytes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_idx <= '0;
            num_lat  <= '0;
            byte_cnt <= '0;
            word     <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        word_idx <= '0;
                        byte_cnt <= '0;
                        num_lat  <= num_words;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end else if (start) begin
                        done  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                LOAD: begin
                    if (byte_acc) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word     <= BIG_ENDIAN ? {word[23:0], byte_data}
                                               : {byte_data, word[31:8]};
                    end
                end
                WRITE:  word_idx <= word_idx + 7'd1;
                FINISH: done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: big- and little-endian instances
// driven by the same byte stream, checked against a word-packing model.
module tb_inst_mem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [6:0]  num_words;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        be_byte_ready, be_mem_we, be_busy, be_done, be_error, be_cpu_hold;
    logic [31:0] be_mem_addr, be_mem_wdata;
    logic        le_byte_ready, le_mem_we, le_busy, le_done, le_error, le_cpu_hold;
    logic [31:0] le_mem_addr, le_mem_wdata;

    inst_mem_loader #(.DEPTH(64), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(be_byte_ready), .mem_we(be_mem_we),
        .mem_addr(be_mem_addr), .mem_wdata(be_mem_wdata),
        .busy(be_busy), .done(be_done), .error(be_error),
        .cpu_hold(be_cpu_hold)
    );

    inst_mem_loader #(.DEPTH(64), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(le_byte_ready), .mem_we(le_mem_we),
        .mem_addr(le_mem_addr), .mem_wdata(le_mem_wdata),
        .busy(le_busy), .done(le_done), .error(le_error),
        .cpu_hold(le_cpu_hold)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    int          we_count = 0;
    int          bad_addr = 0;
    logic [31:0] last_addr = '0;
    logic [7:0]  fixed_q[$];
    logic [31:0] wr_be[$];
    logic [31:0] wr_le[$];

    always @(negedge clk) begin
        if (be_mem_we) begin
            we_count  <= we_count + 1;
            last_addr <= be_mem_addr;
            if (be_mem_addr >= 32'd256) bad_addr <= bad_addr + 1;
        end
    end

    typedef struct {
        logic [6:0] nw;
        bit         exp_err;
        bit         exp_busy;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [31:0] pack(input logic [7:0] b[4], input bit be);
        return be ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(be_byte_ready), 0);
        check({tag, "_we"}, 32'(be_mem_we), 0);
        check({tag, "_addr"}, be_mem_addr, 0);
        check({tag, "_wdata"}, be_mem_wdata, 0);
        check({tag, "_le_wdata"}, le_mem_wdata, 0);
        check({tag, "_busy"}, 32'(be_busy), 0);
        check({tag, "_done"}, 32'(be_done), 0);
        check({tag, "_error"}, 32'(be_error), 0);
        check({tag, "_hold"}, 32'(be_cpu_hold), 1);
    endtask

    task automatic pulse_start(input logic [6:0] n);
        start     = 1'b1;
        num_words = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!be_byte_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t == 64) check("byte_ready_timeout", 0, 1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic run_session(input int n, input int gapmax, input bit fixed,
                               input int abort_at, input int poke_at);
        logic [7:0] b[4];
        int we0;
        int idx;
        we0 = we_count;
        pulse_start(7'(n));
        check("start_busy", 32'(be_busy), 1);
        check("start_done", 32'(be_done), 0);
        check("start_hold", 32'(be_cpu_hold), 1);
        check("start_error", 32'(be_error), 0);
        idx = 0;
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (idx == abort_at) return;
                if (idx == poke_at) begin
                    start     = 1'b1;
                    num_words = 7'd0;
                    @(negedge clk);
                    start     = 1'b0;
                    check("poke_error", 32'(be_error), 0);
                    check("poke_busy", 32'(be_busy), 1);
                end
                b[k] = fixed ? fixed_q[idx] : 8'($urandom);
                repeat ($urandom_range(0, gapmax)) @(negedge clk);
                send_byte(b[k]);
                idx++;
            end
            check("we", 32'(be_mem_we), 1);
            check("le_we", 32'(le_mem_we), 1);
            check("addr", be_mem_addr, 32'(4 * w));
            check("wdata_be", be_mem_wdata, pack(b, 1'b1));
            check("wdata_le", le_mem_wdata, pack(b, 1'b0));
            wr_be.push_back(be_mem_wdata);
            wr_le.push_back(le_mem_wdata);
        end
        @(negedge clk);
        check("finish_done", 32'(be_done), 0);
        check("finish_busy", 32'(be_busy), 0);
        @(negedge clk);
        check("done", 32'(be_done), 1);
        check("hold_release", 32'(be_cpu_hold), 0);
        check("we_per_word", 32'(we_count - we0), 32'(n));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        num_words  = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        #3;
        check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;

        tbl[0] = '{7'd0,   1'b1, 1'b0};
        tbl[1] = '{7'd1,   1'b0, 1'b1};
        tbl[2] = '{7'd65,  1'b1, 1'b0};
        tbl[3] = '{7'd64,  1'b0, 1'b1};
        tbl[4] = '{7'd127, 1'b1, 1'b0};
        tbl[5] = '{7'd33,  1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            pulse_start(tbl[i].nw);
            check($sformatf("tbl%0d_error", i), 32'(be_error), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_busy", i), 32'(be_busy), 32'(tbl[i].exp_busy));
            check($sformatf("tbl%0d_ready", i), 32'(be_byte_ready), 32'(tbl[i].exp_busy));
            check($sformatf("tbl%0d_hold", i), 32'(be_cpu_hold), 1);
            if (tbl[i].exp_busy) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        check("reject_no_we", 32'(we_count), 0);

        fixed_q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        wr_be.delete();
        wr_le.delete();
        run_session(2, 0, 1'b1, -1, -1);
        check("mips_w0", wr_be[0], 32'h8C010004);
        check("mips_w1", wr_be[1], 32'h00000000);

        fixed_q = '{8'h04, 8'h00, 8'h01, 8'h8C};
        wr_le.delete();
        run_session(1, 0, 1'b1, -1, -1);
        check("le_word", wr_le[0], 32'h8C010004);

        for (int s = 0; s < 6; s++) begin
            run_session($urandom_range(1, 8), 5, 1'b0, -1, -1);
        end

        run_session(2, 2, 1'b0, -1, 2);

        run_session(64, 0, 1'b0, -1, -1);
        check("full_last_addr", last_addr, 32'h000000FC);
        check("no_addr_overflow", 32'(bad_addr), 0);

        run_session(4, 1, 1'b0, 14, -1);
        check("pre_abort_busy", 32'(be_busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        reset = 1'b0;
        run_session(1, 3, 1'b0, -1, -1);
        check("restart_addr", last_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
